// File: rtl/secuenciador_dir_dato.sv
// Control sequencer for the shared DIR_DATO address/data bus of the RTC path.
// It runs the init, write and read bursts, with one register per enable_cont_32 slot.
module secuenciador_dir_dato #(
  parameter int TIMEOUT = 64
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [1:0] Control,
  input  logic       enable_cont_32,
  output logic [2:0] Status3bit,
  output logic [3:0] Selec_Mux_DDw,
  output logic       LE,
  output logic       sync,
  output logic       ocupado,
  output logic       listo,
  output logic       error
);

  typedef enum logic [2:0] {
    REPOSO    = 3'b000,
    INIC      = 3'b001,
    ESCRITURA = 3'b010,
    LECTURA   = 3'b100,
    FIN       = 3'b111
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       start;
  logic [7:0] wd;
  logic [3:0] last_code;

  always_comb begin
    case (state)
      INIC:      last_code = 4'd1;
      ESCRITURA: last_code = 4'd7;
      default:   last_code = 4'd10;
    endcase
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      state         <= INIC;
      Status3bit    <= 3'b001;
      Selec_Mux_DDw <= 4'd0;
      LE            <= 1'b0;
      sync          <= 1'b0;
      ocupado       <= 1'b1;
      listo         <= 1'b0;
      error         <= 1'b0;
      start         <= 1'b1;
      wd            <= 8'd0;
    end else begin
      sync  <= 1'b0;
      listo <= 1'b0;
      error <= 1'b0;
      case (state)
        REPOSO: begin
          if (Control != 2'b00) begin
            sync          <= 1'b1;
            ocupado       <= 1'b1;
            wd            <= 8'd0;
            case (Control)
              2'b01: begin
                state         <= INIC;
                Status3bit    <= 3'b001;
                Selec_Mux_DDw <= 4'd0;
                LE            <= 1'b0;
              end
              2'b10: begin
                state         <= LECTURA;
                Status3bit    <= 3'b100;
                Selec_Mux_DDw <= 4'd2;
                LE            <= 1'b1;
              end
              default: begin
                state         <= ESCRITURA;
                Status3bit    <= 3'b010;
                Selec_Mux_DDw <= 4'd2;
                LE            <= 1'b0;
              end
            endcase
          end
        end
        INIC, ESCRITURA, LECTURA: begin
          // The first edge after reset release behaves as a burst entry into INIC.
          if (start) begin
            start         <= 1'b0;
            sync          <= 1'b1;
            Selec_Mux_DDw <= 4'd0;
            wd            <= 8'd0;
          end else if (sync) begin
            wd <= 8'd0;  // pulses that coincide with sync are discarded
          end else if (enable_cont_32) begin
            wd <= 8'd0;
            if (Selec_Mux_DDw == last_code) begin
              state         <= FIN;
              Status3bit    <= 3'b111;
              Selec_Mux_DDw <= 4'd15;
              LE            <= 1'b0;
              listo         <= 1'b1;
            end else begin
              Selec_Mux_DDw <= Selec_Mux_DDw + 4'd1;
            end
          end else if (wd == WD_LAST) begin
            state         <= FIN;
            Status3bit    <= 3'b111;
            Selec_Mux_DDw <= 4'd15;
            LE            <= 1'b0;
            error         <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        FIN: begin
          state      <= REPOSO;
          Status3bit <= 3'b000;
          ocupado    <= 1'b0;
        end
        default: begin
          state         <= REPOSO;
          Status3bit    <= 3'b000;
          Selec_Mux_DDw <= 4'd15;
          LE            <= 1'b0;
          ocupado       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_dir_dato.sv
// Bench for secuenciador_dir_dato: directed vector table, corner-case sequences and
// randomized traffic, all checked against a slot/burst-level reference model.
module tb_secuenciador_dir_dato;

  localparam int TIMEOUT = 64;

  logic       reloj;
  logic       resetM;
  logic [1:0] Control;
  logic       enable_cont_32;
  logic [2:0] Status3bit;
  logic [3:0] Selec_Mux_DDw;
  logic       LE, sync, ocupado, listo, error;

  secuenciador_dir_dato #(.TIMEOUT(TIMEOUT)) dut (
    .reloj(reloj), .resetM(resetM), .Control(Control), .enable_cont_32(enable_cont_32),
    .Status3bit(Status3bit), .Selec_Mux_DDw(Selec_Mux_DDw), .LE(LE), .sync(sync),
    .ocupado(ocupado), .listo(listo), .error(error)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sel;
    logic       le, sy, oc, li, er;
  } out_t;

  typedef struct {
    logic [1:0] ctl;
    logic       en;
    out_t       exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: burst kind, position in its register list, quiet-clock count.
  localparam int M_IDLE = 0, M_INIC = 1, M_WRITE = 2, M_READ = 3, M_FIN = 4;
  int m_mode, m_slot, m_quiet;
  bit m_fresh, m_start, m_err;

  function automatic int burst_len(int m);
    if (m == M_INIC) return 2;
    if (m == M_WRITE) return 6;
    return 9;
  endfunction

  function automatic void model_reset();
    m_mode = M_INIC; m_slot = 0; m_quiet = 0; m_fresh = 0; m_start = 1; m_err = 0;
  endfunction

  function automatic void model_update(logic [1:0] ctl, logic en);
    if (m_mode == M_IDLE) begin
      if (ctl != 2'b00) begin
        m_mode  = (ctl == 2'b01) ? M_INIC : (ctl == 2'b11) ? M_WRITE : M_READ;
        m_slot  = 0; m_fresh = 1; m_quiet = 0;
      end
    end else if (m_mode == M_FIN) begin
      m_mode = M_IDLE;
    end else if (m_start) begin
      m_start = 0; m_fresh = 1; m_slot = 0; m_quiet = 0;
    end else if (m_fresh) begin
      m_fresh = 0; m_quiet = 0;
    end else if (en) begin
      m_quiet = 0;
      if (m_slot == burst_len(m_mode) - 1) begin
        m_mode = M_FIN; m_err = 0;
      end else begin
        m_slot++;
      end
    end else begin
      m_quiet++;
      if (m_quiet >= TIMEOUT) begin
        m_mode = M_FIN; m_err = 1;
      end
    end
  endfunction

  function automatic out_t model_out();
    out_t o;
    case (m_mode)
      M_IDLE:  o.st = 3'b000;
      M_INIC:  o.st = 3'b001;
      M_WRITE: o.st = 3'b010;
      M_READ:  o.st = 3'b100;
      default: o.st = 3'b111;
    endcase
    if (m_mode == M_IDLE || m_mode == M_FIN) o.sel = 4'd15;
    else if (m_mode == M_INIC) o.sel = 4'(m_slot);
    else o.sel = 4'(2 + m_slot);
    o.le = (m_mode == M_READ);
    o.sy = m_fresh;
    o.oc = (m_mode != M_IDLE);
    o.li = (m_mode == M_FIN) && !m_err;
    o.er = (m_mode == M_FIN) && m_err;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.st = Status3bit; o.sel = Selec_Mux_DDw; o.le = LE; o.sy = sync;
    o.oc = ocupado; o.li = listo; o.er = error;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = dut_out();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got st=%b sel=%0d le=%b sync=%b oc=%b listo=%b err=%b, want st=%b sel=%0d le=%b sync=%b oc=%b listo=%b err=%b",
               name, $time, got.st, got.sel, got.le, got.sy, got.oc, got.li, got.er,
               exp.st, exp.sel, exp.le, exp.sy, exp.oc, exp.li, exp.er);
    end
  endtask

  task automatic step(input logic [1:0] ctl, input logic en, input string name);
    Control = ctl;
    enable_cont_32 = en;
    @(posedge reloj);
    #1;
    if (!resetM) model_update(ctl, en);
    check(name, model_out());
  endtask

  function automatic vec_t mk(logic [1:0] c, logic e, logic [2:0] st, logic [3:0] sel,
                              logic le, logic sy, logic oc, logic li, logic er);
    vec_t v;
    v.ctl = c; v.en = e;
    v.exp = '{st: st, sel: sel, le: le, sy: sy, oc: oc, li: li, er: er};
    return v;
  endfunction

  vec_t tbl[11];
  int   cnt;

  // External 32-clock slot counter, restarted whenever sync is expected.
  function automatic logic ext_pulse();
    logic p;
    if (m_fresh) cnt = 0;
    p = (cnt == 31);
    cnt = (cnt + 1) % 32;
    return p;
  endfunction

  initial begin
    tbl[0]  = mk(2'b00, 1'b1, 3'b001, 4'd0,  0, 1, 1, 0, 0);
    tbl[1]  = mk(2'b00, 1'b1, 3'b001, 4'd0,  0, 0, 1, 0, 0);
    tbl[2]  = mk(2'b00, 1'b0, 3'b001, 4'd0,  0, 0, 1, 0, 0);
    tbl[3]  = mk(2'b00, 1'b1, 3'b001, 4'd1,  0, 0, 1, 0, 0);
    tbl[4]  = mk(2'b10, 1'b0, 3'b001, 4'd1,  0, 0, 1, 0, 0);
    tbl[5]  = mk(2'b00, 1'b1, 3'b111, 4'd15, 0, 0, 1, 1, 0);
    tbl[6]  = mk(2'b00, 1'b1, 3'b000, 4'd15, 0, 0, 0, 0, 0);
    tbl[7]  = mk(2'b10, 1'b0, 3'b100, 4'd2,  1, 1, 1, 0, 0);
    tbl[8]  = mk(2'b00, 1'b1, 3'b100, 4'd2,  1, 0, 1, 0, 0);
    tbl[9]  = mk(2'b00, 1'b1, 3'b100, 4'd3,  1, 0, 1, 0, 0);
    tbl[10] = mk(2'b00, 1'b0, 3'b100, 4'd3,  1, 0, 1, 0, 0);

    resetM = 1'b1; Control = 2'b00; enable_cont_32 = 1'b0; cnt = 0;
    model_reset();
    #12;
    check("reset_values", model_out());
    resetM = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].ctl, tbl[i].en, "table_model");
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Finish the read burst with regular 32-clock slots.
    cnt = 2;
    for (int i = 0; i < 400 && m_mode != M_IDLE; i++) step(2'b00, ext_pulse(), "read_burst");

    // Write burst; request switched to read mid-burst must be ignored until REPOSO.
    step(2'b11, 1'b0, "write_entry");
    for (int i = 0; i < 400 && m_mode != M_IDLE; i++)
      step((i < 40) ? 2'b11 : 2'b10, ext_pulse(), "write_burst");
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0, "after_write");

    // Held read request: back-to-back read bursts.
    for (int i = 0; i < 700; i++) step(2'b10, ext_pulse(), "held_read");
    for (int i = 0; i < 400 && m_mode != M_IDLE; i++) step(2'b00, ext_pulse(), "held_drain");

    // Watchdog: no slot pulses during a read burst.
    begin
      bit saw_err = 0;
      step(2'b10, 1'b0, "tmo_entry");
      for (int i = 0; i < 200 && m_mode != M_IDLE; i++) begin
        step(2'b00, 1'b0, "tmo_wait");
        if (error) saw_err = 1;
      end
      vectors++;
      if (!saw_err) begin
        miscompares++;
        $display("FAIL timeout_error: got error pulse=0, want 1");
      end
    end

    // Asynchronous reset during read slot 5.
    step(2'b10, 1'b0, "rst_entry");
    for (int i = 0; i < 400 && !(m_mode == M_READ && m_slot == 5); i++)
      step(2'b00, ext_pulse(), "rst_run");
    step(2'b00, 1'b0, "rst_slot5");
    resetM = 1'b1;
    #1;
    model_reset();
    check("async_reset", model_out());
    step(2'b10, 1'b1, "rst_held");
    resetM = 1'b0;
    for (int i = 0; i < 120 && m_mode != M_IDLE; i++) step(2'b00, ext_pulse(), "reinit");

    // Randomized traffic with mixed pulse regimes and occasional resets.
    begin
      logic [1:0] ctl = 2'b00;
      int regime = 0;
      for (int i = 0; i < 6000; i++) begin
        logic en;
        if (i % 200 == 0) regime = $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0)
          ctl = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        if (regime == 0) en = ext_pulse();
        else if (regime == 1) en = ($urandom_range(0, 19) == 0);
        else en = 1'b0;
        if ($urandom_range(0, 1499) == 0) begin
          resetM = 1'b1;
          #1;
          model_reset();
          check("rand_async_reset", model_out());
          #2;
          resetM = 1'b0;
        end
        step(ctl, en, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secuenciador_dir_dato.md
# secuenciador_dir_dato

Control sequencer for the shared 8-bit `DIR_DATO` address/data bus datapath of the RTC path.
- Runs the initialization, write bursts and read bursts on the bus, one register per 32-clock slot.
- Paced by the external `enable_cont_32` time base.
- Supplies the inter-modular control set that the mux/demux datapath consumes: `Status3bit`, `Selec_Mux_DDw`, `LE` and `sync`.

## Interface
Parameters:
- `TIMEOUT`, 64: clocks allowed between slot advances before a burst is aborted.

Ports:
- `reloj`  in  1  system clock; all logic on rising edge.
- `resetM`  in  1  asynchronous, active-high reset.
- `Control`  in  2  request code, sampled only in REPOSO:
  - 00 none
  - 01 re-initialize
  - 10 read burst
  - 11 write burst
- `enable_cont_32`  in  1  one-cycle pulse every 32 clocks from the external slot counter.
- `Status3bit`  out  3  state code:
  - 000 REPOSO
  - 001 INIC
  - 010 ESCRITURA
  - 100 LECTURA
  - 111 FIN
- `Selec_Mux_DDw`  out  4  register selected for the current slot:
  - 0 Inicie, 1 Mod_S
  - 2 diaf, 3 mesf, 4 anof
  - 5 segh, 6 minh, 7 horah
  - 8 segcr, 9 mincr, 10 horacr
  - 15 none
- `LE`  out  1  capture-latch enable; high for the whole LECTURA state.
- `sync`  out  1  one-cycle pulse that restarts the external 32-counter at burst start.
- `ocupado`  out  1  high in any state other than REPOSO.
- `listo`  out  1  one-cycle pulse in FIN on normal completion.
- `error`  out  1  one-cycle pulse in FIN when a burst was aborted by timeout.

## Operation
- All outputs are registered.
- **Reset values:** state INIC, `Status3bit`=001, `Selec_Mux_DDw`=0, `LE`=0, `sync`=0, `ocupado`=1, `listo`=0, `error`=0. An internal start flag is set.
- **Burst entry:** on entry to INIC, ESCRITURA or LECTURA (including the first clock after reset release), `sync`=1 for exactly one cycle and the slot code is set to the first code.
  - An `enable_cont_32` pulse arriving in the same cycle as `sync` is ignored.
- **Slot sequences:**
  - INIC: codes 0,1 (2 slots).
  - ESCRITURA: codes 2..7 (6 slots).
  - LECTURA: codes 2..10 (9 slots).
- **Slot advance:** each accepted `enable_cont_32` pulse advances to the next code. The pulse received while on the last code moves the block to FIN.
- **FIN:** lasts 1 cycle, with `Status3bit`=111, `Selec_Mux_DDw`=15, `LE`=0, and `listo` or `error` pulsed. The next state is REPOSO.
- **REPOSO:** `Selec_Mux_DDw`=15, `ocupado`=0. A nonzero `Control` sampled at a clock edge starts the matching state at that edge.
- **Requests while busy:** `Control` is ignored in INIC, ESCRITURA, LECTURA and FIN. No queuing.
- **Held request:** `Control` held at 10 gives back-to-back read bursts separated by FIN + REPOSO (2 idle cycles).
- **Timeout:** an 8-bit watchdog counter clears on `sync` and on every accepted pulse, and increments otherwise.
  - Reaching `TIMEOUT` in a burst state goes to FIN with `error`=1, `listo`=0.
- **Asynchronous reset:** `resetM` asserted at any time, including mid-burst, forces the reset values immediately. Release restarts INIC.

## Timing
- Request latency: `Control` sampled at edge k gives state, `sync`=1 and the first code visible after edge k. `sync` drops after edge k+1.
- With the external counter cleared by `sync`, the first slot advance is about 32 clocks later.
- Slot length equals the `enable_cont_32` period.
- LECTURA lasts 9 slots; ESCRITURA lasts 6; INIC lasts 2. Each is followed by exactly 1 FIN cycle.
- `LE` rises in the same cycle as `Status3bit`=100 and falls on entry to FIN.
- `Selec_Mux_DDw` changes only on the edge that accepts a pulse, or on state entry/exit.

## Test plan
- Reset then release, 32-clock pulses → `sync` pulse 1 cycle after release; codes 0,1; FIN with `listo`=1; REPOSO with `Status3bit`=000 and `Selec_Mux_DDw`=15.
- `Control`=10 in REPOSO → `Status3bit`=100, `LE`=1, codes 2..10 for 32 clocks each, FIN `listo`=1, `LE`=0. Total 1 + 9×32 + 1 cycles ±1.
- `Control`=11, then `Control` changed to 10 mid-burst → codes 2..7 only, `LE` stays 0, new request ignored until REPOSO.
- Pulse coincident with the `sync` cycle → ignored; first code held until the next pulse.
- Suppress `enable_cont_32` during LECTURA → after 64 clocks FIN with `error`=1, `listo`=0, then REPOSO.
- Assert `resetM` during LECTURA slot 5 → outputs immediately at reset values (`LE`=0, `Status3bit`=001); after release INIC restarts with `sync` pulse.
